// File: rtl/regdst_pipe_if.sv
// Decode-side bundle for regdst_pipe: instruction destination fields in,
// per-stage destination state, write-back port and hazard flags out.
interface regdst_pipe_if #(
  parameter int AW     = 5,
  parameter int STAGES = 3
);
  logic                  in_valid;
  logic [AW-1:0]         rt_addr;
  logic [AW-1:0]         rd_addr;
  logic [1:0]            reg_dst;
  logic                  reg_write;
  logic                  stall;
  logic                  flush;
  logic [AW-1:0]         src_a;
  logic [AW-1:0]         src_b;
  logic [STAGES*AW-1:0]  stage_addr;
  logic [STAGES-1:0]     stage_we;
  logic                  out_valid;
  logic [AW-1:0]         out_addr;
  logic                  out_we;
  logic                  hazard_a;
  logic                  hazard_b;

  modport master (
    output in_valid, rt_addr, rd_addr, reg_dst, reg_write, stall, flush, src_a, src_b,
    input  stage_addr, stage_we, out_valid, out_addr, out_we, hazard_a, hazard_b
  );

  modport slave (
    input  in_valid, rt_addr, rd_addr, reg_dst, reg_write, stall, flush, src_a, src_b,
    output stage_addr, stage_we, out_valid, out_addr, out_we, hazard_a, hazard_b
  );
endinterface

// File: rtl/regdst_pipe.sv
// Destination-register select (rt / rd / link) followed by a STAGES-deep
// {valid, addr, we} pipeline toward write-back, with RAW hazard flags.
module regdst_pipe #(
  parameter int AW      = 5,
  parameter int STAGES  = 3,
  parameter int RA_ADDR = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  regdst_pipe_if.slave  bus
);

  logic [AW-1:0]         sel_addr;
  logic                  sel_we;
  logic [STAGES-1:0]     valid_q, valid_d;
  logic [STAGES-1:0]     we_q, we_d;
  logic [STAGES*AW-1:0]  addr_q, addr_d;
  logic                  hazard_a;
  logic                  hazard_b;

  always_comb begin
    case (bus.reg_dst)
      2'b00:   sel_addr = bus.rt_addr;
      2'b01:   sel_addr = bus.rd_addr;
      2'b10:   sel_addr = AW'(RA_ADDR);
      default: sel_addr = '0;
    endcase
    // Register 0 is hard-wired, so a write to it is dropped before it can
    // ever raise a hazard downstream.
    sel_we = bus.in_valid & bus.reg_write & (bus.reg_dst != 2'b11) & (sel_addr != '0);
  end

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    if (bus.flush) begin
      valid_d = '0;
      we_d    = '0;
      addr_d  = '0;
    end else if (!bus.stall) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        valid_d[k]          = valid_q[k-1];
        we_d[k]             = we_q[k-1];
        addr_d[k*AW +: AW]  = addr_q[(k-1)*AW +: AW];
      end
      valid_d[0]     = bus.in_valid;
      we_d[0]        = sel_we;
      addr_d[AW-1:0] = sel_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      we_q    <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (valid_q[k] && we_q[k] && (addr_q[k*AW +: AW] == bus.src_a)) hazard_a = 1'b1;
      if (valid_q[k] && we_q[k] && (addr_q[k*AW +: AW] == bus.src_b)) hazard_b = 1'b1;
    end
  end

  assign bus.stage_addr = addr_q;
  assign bus.stage_we   = valid_q & we_q;
  assign bus.out_valid  = valid_q[STAGES-1];
  assign bus.out_addr   = addr_q[(STAGES-1)*AW +: AW];
  assign bus.out_we     = valid_q[STAGES-1] & we_q[STAGES-1];
  assign bus.hazard_a   = hazard_a;
  assign bus.hazard_b   = hazard_b;

endmodule

// File: tb/tb_regdst_pipe.sv
// Bench for regdst_pipe: a model of "the last STAGES accepted entries" is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_regdst_pipe;
  localparam int AW = 5;
  localparam int S  = 3;
  localparam int RA = 31;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic          we;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  regdst_pipe_if #(.AW(AW), .STAGES(S)) bus ();

  regdst_pipe #(.AW(AW), .STAGES(S), .RA_ADDR(RA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  entry_t hist[$];

  function automatic entry_t select_entry(logic v, logic [AW-1:0] rt, logic [AW-1:0] rd,
                                          logic [1:0] mode, logic rw);
    entry_t e;
    int a;
    if (mode == 2'd0)      a = int'(rt);
    else if (mode == 2'd1) a = int'(rd);
    else if (mode == 2'd2) a = RA;
    else                   a = 0;
    e.valid = v;
    e.addr  = AW'(a);
    e.we    = v && rw && (mode != 2'd3) && (a != 0);
    return e;
  endfunction

  task automatic clear_model();
    hist.delete();
    for (int k = 0; k < S; k++) hist.push_back(entry_t'(0));
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: stage k always shows the k-th most recently accepted entry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) clear_model();
    else if (bus.flush) clear_model();
    else if (!bus.stall) begin
      hist.push_front(select_entry(bus.in_valid, bus.rt_addr, bus.rd_addr,
                                   bus.reg_dst, bus.reg_write));
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [S*AW-1:0] exp_addr;
      logic [S-1:0]    exp_we;
      logic            ha, hb;
      ha = 1'b0;
      hb = 1'b0;
      for (int k = 0; k < S; k++) begin
        exp_addr[k*AW +: AW] = hist[k].addr;
        exp_we[k]            = hist[k].valid & hist[k].we;
        if (exp_we[k] && hist[k].addr == bus.src_a) ha = 1'b1;
        if (exp_we[k] && hist[k].addr == bus.src_b) hb = 1'b1;
      end
      chk("model stage_addr", 32'(bus.stage_addr), 32'(exp_addr));
      chk("model stage_we",   32'(bus.stage_we),   32'(exp_we));
      chk("model out_valid",  32'(bus.out_valid),  32'(hist[S-1].valid));
      chk("model out_addr",   32'(bus.out_addr),   32'(hist[S-1].addr));
      chk("model out_we",     32'(bus.out_we),     32'(hist[S-1].valid & hist[S-1].we));
      chk("model hazard_a",   32'(bus.hazard_a),   32'(ha));
      chk("model hazard_b",   32'(bus.hazard_b),   32'(hb));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic present(logic v, logic [AW-1:0] rt, logic [AW-1:0] rd, logic [1:0] mode, logic rw);
    bus.in_valid  = v;
    bus.rt_addr   = rt;
    bus.rd_addr   = rd;
    bus.reg_dst   = mode;
    bus.reg_write = rw;
  endtask

  task automatic idle();
    present(1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    idle();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    #2;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset stage_addr", 32'(bus.stage_addr), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Mode sweep
    present(1'b1, 5'd5, 5'd9, 2'b00, 1'b1); tick();
    present(1'b1, 5'd5, 5'd9, 2'b01, 1'b1); tick();
    present(1'b1, 5'd5, 5'd9, 2'b10, 1'b1); tick();
    chk("sweep rt addr", 32'(bus.out_addr), 32'd5);
    chk("sweep rt we",   32'(bus.out_we),   32'd1);
    present(1'b1, 5'd5, 5'd9, 2'b11, 1'b1); tick();
    chk("sweep rd addr", 32'(bus.out_addr), 32'd9);
    chk("sweep rd we",   32'(bus.out_we),   32'd1);
    idle(); tick();
    chk("sweep ra addr", 32'(bus.out_addr), 32'd31);
    chk("sweep ra we",   32'(bus.out_we),   32'd1);
    tick();
    chk("sweep none addr",  32'(bus.out_addr),  32'd0);
    chk("sweep none we",    32'(bus.out_we),    32'd0);
    chk("sweep none valid", 32'(bus.out_valid), 32'd1);
    tick(); tick();

    // Register-0 suppression
    bus.src_a = '0;
    present(1'b1, 5'd3, 5'd0, 2'b01, 1'b1); tick();
    chk("r0 hazard_a s0", 32'(bus.hazard_a), 32'd0);
    idle(); tick();
    chk("r0 hazard_a s1", 32'(bus.hazard_a), 32'd0);
    tick();
    chk("r0 out_valid", 32'(bus.out_valid), 32'd1);
    chk("r0 out_we",    32'(bus.out_we),    32'd0);
    chk("r0 hazard_a",  32'(bus.hazard_a),  32'd0);
    tick();

    // Hazard tracking
    bus.src_a = 5'd7;
    bus.src_b = 5'd8;
    present(1'b1, 5'd1, 5'd7, 2'b01, 1'b1);
    #1;
    chk("haz before", 32'(bus.hazard_a), 32'd0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      chk("haz in flight a", 32'(bus.hazard_a), 32'd1);
      chk("haz in flight b", 32'(bus.hazard_b), 32'd0);
      tick();
    end
    chk("haz drop a", 32'(bus.hazard_a), 32'd0);
    bus.src_a = '0;
    bus.src_b = '0;
    tick();

    // Stall
    present(1'b1, 5'd0, 5'd12, 2'b01, 1'b1); tick();
    idle();
    bus.stall = 1'b1;
    tick(); tick();
    chk("stall hold s0", 32'(bus.stage_addr), 32'd12);
    chk("stall hold we", 32'(bus.stage_we),   32'b001);
    bus.stall = 1'b0;
    tick();
    chk("stall not yet", 32'(bus.out_valid), 32'd0);
    tick();
    chk("stall out addr", 32'(bus.out_addr), 32'd12);
    chk("stall out we",   32'(bus.out_we),   32'd1);
    tick();

    // Flush overrides stall
    present(1'b1, 5'd0, 5'd3, 2'b01, 1'b1); tick();
    present(1'b1, 5'd0, 5'd4, 2'b01, 1'b1); tick();
    present(1'b1, 5'd0, 5'd6, 2'b01, 1'b1); tick();
    idle();
    bus.src_a = 5'd3;
    bus.src_b = 5'd6;
    #1;
    chk("flush pre we", 32'(bus.stage_we), 32'b111);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    chk("flush stage_we",  32'(bus.stage_we),  32'd0);
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush hazard_a",  32'(bus.hazard_a),  32'd0);
    chk("flush hazard_b",  32'(bus.hazard_b),  32'd0);
    tick();

    // Asynchronous reset
    bus.src_a = 5'd10;
    present(1'b1, 5'd10, 5'd0, 2'b00, 1'b1); tick();
    present(1'b1, 5'd11, 5'd0, 2'b00, 1'b1); tick();
    idle();
    chk("ar pre hazard", 32'(bus.hazard_a), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar stage_addr", 32'(bus.stage_addr), 32'd0);
    chk("ar stage_we",   32'(bus.stage_we),   32'd0);
    chk("ar out",        32'({bus.out_valid, bus.out_addr, bus.out_we}), 32'd0);
    chk("ar hazards",    32'({bus.hazard_a, bus.hazard_b}), 32'd0);
    tick();
    rst_n = 1'b1;
    present(1'b1, 5'd0, 5'd20, 2'b01, 1'b1); tick();
    idle(); tick();
    chk("ar early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("ar new addr",  32'(bus.out_addr),  32'd20);
    chk("ar new valid", 32'(bus.out_valid), 32'd1);
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
